// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mini_cpu_pkg
//  Purpose  : Shared widths, the NOP/flush instruction constant and the
//             occupancy state type for the fetch/decode pipeline stage.
//  Contents : INSTR_W_DEF, PC_W_DEF  - default payload widths
//             NOP_INSTR              - value shown on an empty/flushed stage
//             occ_state_t            - EMPTY / ONE / FULL occupancy
//  Revision : 1.0 - initial release
// ============================================================================
package mini_cpu_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int PC_W_DEF    = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
//  Interface : pipe_stage_skid_if
//  Purpose   : One valid/ready stream carrying an instruction and its PC.
//  Signals   : valid - producer offers instr/pc
//              ready - consumer accepts this cycle
//              instr - instruction payload (INSTR_W)
//              pc    - program counter payload (PC_W)
//  Modports  : master - producer side, slave - consumer side
//  Revision  : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
    parameter int INSTR_W = mini_cpu_pkg::INSTR_W_DEF,
    parameter int PC_W    = mini_cpu_pkg::PC_W_DEF
);
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;

    modport master (output valid, output instr, output pc, input  ready);
    modport slave  (input  valid, input  instr, input  pc, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid_entry.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_entry
//  Purpose  : One storage slot of the stage: valid bit plus instr/pc payload.
//             Reset or clear empties the slot and parks the payload at
//             CLEAR_INSTR / 0 so an empty slot shows a harmless value.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             load, clear     - capture d_* / empty the slot (clear wins)
//             d_instr, d_pc   - data to capture
//             valid, instr, pc- registered slot contents
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_entry #(
    parameter int                 INSTR_W     = 32,
    parameter int                 PC_W        = 32,
    parameter logic [INSTR_W-1:0] CLEAR_INSTR = '0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               load,
    input  wire logic               clear,
    input  wire logic [INSTR_W-1:0] d_instr,
    input  wire logic [PC_W-1:0]    d_pc,
    output logic                    valid,
    output logic [INSTR_W-1:0]      instr,
    output logic [PC_W-1:0]         pc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            instr <= CLEAR_INSTR;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Pipeline register stage for instruction/PC with optional
//             two-entry skid buffer, flush and stall/flush statistics.
//  Ports    : clk, reset   - clock, synchronous active-high reset
//             flush        - drop held entries and any same-cycle accept
//             up   (slave) - upstream stream (in_valid/in_ready/in_instr/in_pc)
//             down (master)- downstream stream (out_valid/out_ready/...)
//             out_noflush  - head entry is live (mirrors out_valid)
//             stall_cnt    - saturating count of out_valid & !out_ready cycles
//             flush_cnt    - saturating count of flush cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import mini_cpu_pkg::*;
#(
    parameter int                 INSTR_W     = INSTR_W_DEF,
    parameter int                 PC_W        = PC_W_DEF,
    parameter int                 SKID_EN     = 1,
    parameter logic [INSTR_W-1:0] FLUSH_INSTR = INSTR_W'(NOP_INSTR),
    parameter int                 CNT_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          flush,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  down,
    output logic               out_noflush,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    occ_state_t         state;

    logic               accept;
    logic               retire;

    logic               head_valid;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;
    logic               head_load;
    logic               head_clear;
    logic               head_from_skid;
    logic [INSTR_W-1:0] head_d_instr;
    logic [PC_W-1:0]    head_d_pc;

    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;
    logic               skid_load;
    logic               skid_clear;

    assign accept = up.valid && up.ready;
    assign retire = head_valid && down.ready;

    // Slot control. Flush empties both slots regardless of handshakes.
    always_comb begin
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: head_load = accept;
                OCC_ONE: begin
                    if (accept && retire) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (retire) begin
                        head_clear = 1'b1;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only the skid can refill head
                    if (retire) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign head_d_instr = head_from_skid ? skid_instr : up.instr;
    assign head_d_pc    = head_from_skid ? skid_pc    : up.pc;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state <= OCC_ONE;
                OCC_ONE: begin
                    if (accept && !retire) begin
                        state <= OCC_FULL;
                    end else if (!accept && retire) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL:  if (retire) state <= OCC_ONE;
                default:   state <= OCC_EMPTY;
            endcase
        end
    end

    pipe_entry #(
        .INSTR_W     (INSTR_W),
        .PC_W        (PC_W),
        .CLEAR_INSTR (FLUSH_INSTR)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .load    (head_load),
        .clear   (head_clear),
        .d_instr (head_d_instr),
        .d_pc    (head_d_pc),
        .valid   (head_valid),
        .instr   (head_instr),
        .pc      (head_pc)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_entry #(
                .INSTR_W     (INSTR_W),
                .PC_W        (PC_W),
                .CLEAR_INSTR (FLUSH_INSTR)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .load    (skid_load),
                .clear   (skid_clear),
                .d_instr (up.instr),
                .d_pc    (up.pc),
                .valid   (skid_valid),
                .instr   (skid_instr),
                .pc      (skid_pc)
            );
            // Taken straight from a flop: no path from down.ready.
            assign up.ready = !skid_valid;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_instr = FLUSH_INSTR;
            assign skid_pc    = '0;
            assign up.ready   = !head_valid || down.ready;
        end
    endgenerate

    assign down.valid  = head_valid;
    assign down.instr  = head_instr;
    assign down.pc     = head_pc;
    assign out_noflush = head_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (head_valid && !down.ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Purpose  : Self-checking bench. Two stages share one stimulus stream:
//             dut A = skid mode, 16-bit counters, FLUSH_INSTR 0x13;
//             dut B = single-entry mode, 4-bit counters, default FLUSH_INSTR.
//             Each is compared with a queue-based occupancy model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    pipe_stage_skid_if #(.INSTR_W(32), .PC_W(32)) up_a ();
    pipe_stage_skid_if #(.INSTR_W(32), .PC_W(32)) dn_a ();
    pipe_stage_skid_if #(.INSTR_W(32), .PC_W(32)) up_b ();
    pipe_stage_skid_if #(.INSTR_W(32), .PC_W(32)) dn_b ();

    assign up_a.valid = in_valid;
    assign up_a.instr = in_instr;
    assign up_a.pc    = in_pc;
    assign dn_a.ready = out_ready;
    assign up_b.valid = in_valid;
    assign up_b.instr = in_instr;
    assign up_b.pc    = in_pc;
    assign dn_b.ready = out_ready;

    logic        noflush_a, noflush_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    pipe_stage_skid #(
        .INSTR_W(32), .PC_W(32), .SKID_EN(1),
        .FLUSH_INSTR(32'h0000_0013), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .up(up_a), .down(dn_a),
        .out_noflush(noflush_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_stage_skid #(
        .INSTR_W(32), .PC_W(32), .SKID_EN(0), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .up(up_b), .down(dn_b),
        .out_noflush(noflush_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: entries held, expected stream order, counters.
    typedef logic [63:0] item_t;
    item_t q0[$];
    item_t q1[$];
    int    occ[2];
    int    stall_m[2];
    int    flush_m[2];
    bit    clr[2];

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic        nf;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [15:0] st;
        logic [15:0] fc;
    } obs_t;

    function automatic obs_t obs(input int k);
        obs_t o;
        if (k == 0) o = {up_a.ready, dn_a.valid, noflush_a, dn_a.instr, dn_a.pc, stall_a, flush_a};
        else        o = {up_b.ready, dn_b.valid, noflush_b, dn_b.instr, dn_b.pc, 12'd0, stall_b, 12'd0, flush_b};
        return o;
    endfunction

    function automatic item_t front(input int k);
        if (k == 0) return (q0.size() > 0) ? q0[0] : '1;
        else        return (q1.size() > 0) ? q1[0] : '1;
    endfunction

    task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic mon_pop(input int k, input item_t act);
        item_t e;
        checks++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL release dut%0d @%0t: got %h expected no release", k, $time, act);
        end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL release_data dut%0d @%0t: got %h expected %h", k, $time, act, e);
            end
        end
    endtask

    // Monitor: every downstream handshake must deliver the oldest queued entry.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && out_ready === 1'b1) begin
                if (dn_a.valid === 1'b1) mon_pop(0, {dn_a.instr, dn_a.pc});
                if (dn_b.valid === 1'b1) mon_pop(1, {dn_b.instr, dn_b.pc});
            end
        end
    end

    // One cycle: drive, check current outputs against model, advance model.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                        input bit ordy, input bit fl, input bit rs);
        obs_t        o;
        bit          exp_rdy;
        bit          acc;
        bit          rel;
        int          cmax;
        logic [31:0] fli;
        reset = rs; flush = fl; in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy;
        #1;
        for (int k = 0; k < 2; k++) begin
            o       = obs(k);
            cmax    = (k == 0) ? 65535 : 15;
            fli     = (k == 0) ? 32'h0000_0013 : 32'h0000_0000;
            exp_rdy = (k == 0) ? (occ[k] < 2) : (occ[k] == 0 || ordy);
            chk(k, "in_ready",    64'(o.rdy), 64'(exp_rdy));
            chk(k, "out_valid",   64'(o.vld), 64'(occ[k] > 0));
            chk(k, "out_noflush", 64'(o.nf),  64'(occ[k] > 0));
            if (occ[k] == 0) chk(k, "empty_payload", {o.instr, o.pc}, {fli, 32'd0});
            else             chk(k, "head_payload",  {o.instr, o.pc}, front(k));
            chk(k, "stall_cnt", 64'(o.st), 64'(stall_m[k]));
            chk(k, "flush_cnt", 64'(o.fc), 64'(flush_m[k]));
            rel = (occ[k] > 0) && ordy;
            acc = v && exp_rdy;
            if (rs) begin
                occ[k] = 0; stall_m[k] = 0; flush_m[k] = 0; clr[k] = 1'b1;
            end else begin
                if (occ[k] > 0 && !ordy && stall_m[k] < cmax) stall_m[k]++;
                if (fl && flush_m[k] < cmax) flush_m[k]++;
                if (fl) begin
                    occ[k] = 0; clr[k] = 1'b1;
                end else begin
                    occ[k] = occ[k] + int'(acc) - int'(rel);
                    if (acc) begin
                        if (k == 0) q0.push_back({ins, p});
                        else        q1.push_back({ins, p});
                    end
                end
            end
        end
        @(posedge clk);
        #2;
        if (clr[0]) begin q0.delete(); clr[0] = 1'b0; end
        if (clr[1]) begin q1.delete(); clr[1] = 1'b0; end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        for (int k = 0; k < 2; k++) begin
            occ[k] = 0; stall_m[k] = 0; flush_m[k] = 0; clr[k] = 1'b0;
        end
        @(posedge clk);
        #2;
        step(0, 32'h0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0, 1);

        // Single instruction, one-cycle latency
        step(1, 32'h0050_0093, 32'h100, 1, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Back-to-back stream
        for (int i = 0; i < 4; i++) step(1, 32'h1000_0000 + i, 32'(i * 4), 1, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Downstream stalls under continuous input, then drain
        step(1, 32'hA000_0001, 32'h200, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'hA000_0002 + i, 32'h204 + 32'(i * 4), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 1, 0, 0);

        // Fill, then flush with a same-cycle input offer
        step(1, 32'hB000_0001, 32'h300, 0, 0, 0);
        step(1, 32'hB000_0002, 32'h304, 0, 0, 0);
        step(1, 32'hB000_0003, 32'h308, 0, 1, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Long stall: the 4-bit counter must saturate at 15 and hold
        step(1, 32'hC000_0001, 32'h400, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 32'hC000_0002 + i, 32'h404 + 32'(i * 4), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0, 0);

        // out_ready toggling 1,0,1 under continuous input
        for (int i = 0; i < 9; i++) step(1, 32'hD000_0000 + i, 32'h500 + 32'(i * 4), (i % 3) != 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0, 0);

        // Mid-operation reset with a pending release
        step(1, 32'hE000_0001, 32'h600, 0, 0, 0);
        step(1, 32'hE000_0002, 32'h604, 0, 0, 0);
        step(1, 32'hE000_0003, 32'h608, 1, 1, 1);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, $urandom,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 1, 0, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter INSTR_W, default 32, instruction payload width.
REQ-002 Parameter PC_W, default 32, program-counter payload width.
REQ-003 Parameter SKID_EN, default 1; 1 = two-entry skid mode, 0 = single-entry mode.
REQ-004 Parameter FLUSH_INSTR, default 0 (INSTR_W bits), instruction value presented when the stage is empty or flushed.
REQ-005 Parameter CNT_W, default 16, width of the statistics counters.
REQ-006 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: reset, synchronous and active-high.
REQ-008 Port in_valid, input, 1: upstream offers in_instr/in_pc.
REQ-009 Port in_ready, output, 1: stage can accept this cycle.
REQ-010 Port in_instr, input, INSTR_W: fetched instruction.
REQ-011 Port in_pc, input, PC_W: PC of in_instr.
REQ-012 Port flush, input, 1: discard all held and incoming entries.
REQ-013 Port out_valid, output, 1: out_instr/out_pc hold a live entry.
REQ-014 Port out_ready, input, 1: downstream consumes this cycle.
REQ-015 Port out_instr, output, INSTR_W: head-entry instruction.
REQ-016 Port out_pc, output, PC_W: head-entry PC.
REQ-017 Port out_noflush, output, 1: head entry is live (not flushed), equal to out_valid.
REQ-018 Port stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0.
REQ-019 Port flush_cnt, output, CNT_W: cycles with flush=1.

Function
REQ-020 Accept = in_valid and in_ready; release = out_valid and out_ready; flush overrides both.
REQ-021 Storage SHALL be a head entry (drives outputs) and, when SKID_EN=1, a skid entry; occupancy states EMPTY, ONE, FULL.
REQ-022 SKID_EN=1: in_ready SHALL be registered, equal to "skid entry empty"; never combinationally dependent on out_ready.
REQ-023 SKID_EN=0: in_ready SHALL be (head empty) or out_ready; state FULL unreachable.
REQ-024 EMPTY + accept: head loads input, next state ONE; latency accept-to-out_valid is exactly 1 cycle.
REQ-025 ONE + accept + release: head loads input, stay ONE (full throughput, one per cycle).
REQ-026 ONE + accept, no release: skid loads input, next FULL.
REQ-027 ONE + release, no accept: next EMPTY.
REQ-028 FULL + release: head loads skid contents, next ONE; in_ready=0 during FULL, so no accept.
REQ-029 While out_valid=1 and out_ready=0, out_instr/out_pc SHALL stay stable; order of entries SHALL be preserved.
REQ-030 flush=1: next cycle state EMPTY, both entries invalid, in_ready=1; an accept in the same cycle is discarded; a release in the same cycle still counts as consumed downstream.
REQ-031 When head is invalid, out_instr SHALL equal FLUSH_INSTR and out_pc SHALL equal 0.
REQ-032 stall_cnt and flush_cnt SHALL increment by 1 per qualifying cycle and saturate at all-ones; no wrap.

Reset
REQ-033 On reset: state EMPTY, out_valid=0, out_noflush=0, out_instr=FLUSH_INSTR, out_pc=0, in_ready=1, stall_cnt=0, flush_cnt=0.
REQ-034 Reset mid-operation SHALL drop all entries without a release; reset has priority over flush.

Structure
REQ-035 Package mini_cpu_pkg SHALL hold INSTR_W/PC_W defaults, the NOP/flush instruction constant and the EMPTY/ONE/FULL state type.
REQ-036 One sub-module pipe_entry (valid bit plus instr/pc payload with load and clear) SHALL be instantiated for head and, when SKID_EN=1, for skid.

Verification
REQ-037 Reset, then in_valid=1 instr=0x00500093 pc=0x100, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_pc=0x100.
REQ-038 Back-to-back stream pc 0x0,0x4,0x8,0xC with out_ready=1 -> one release per cycle, order preserved, stall_cnt=0.
REQ-039 SKID_EN=1, out_ready=0 for 3 cycles with in_valid=1 -> second entry captured, in_ready=0 from next cycle, stall_cnt=3, no data lost after out_ready=1.
REQ-040 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_noflush=0, out_instr=FLUSH_INSTR, out_pc=0, in_ready=1, flush_cnt=1.
REQ-041 CNT_W=4, out_ready=0 held 20 cycles with out_valid=1 -> stall_cnt=15, holds.
REQ-042 SKID_EN=0, out_ready toggled 1,0,1 under continuous input -> in_ready tracks out_ready when head valid, no duplicates or drops.
